// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between cpu and debug ports; one word per transfer.
// Latency MEM_LATENCY+2 per transfer; losing requests stay pending. DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN selects fixed cpu priority.
module data_memory_arbiter #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_grant,
  output logic                  cpu_done,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_write,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_grant,
  output logic                  dbg_done,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_enable,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [3:0] LAT_M1   = 4'(MEM_LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  win_dbg_q, win_dbg_d;
  logic                  cpu_grant_q, cpu_grant_d;
  logic                  dbg_grant_q, dbg_grant_d;
  logic                  cpu_done_q, cpu_done_d;
  logic                  dbg_done_q, dbg_done_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic                  mem_enable_q, mem_enable_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic                  pick_dbg;
`ifndef DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN
  logic                  last_dbg_q, last_dbg_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    win_dbg_d    = win_dbg_q;
    cpu_grant_d  = 1'b0;
    dbg_grant_d  = 1'b0;
    cpu_done_d   = 1'b0;
    dbg_done_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
`ifdef DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN
    pick_dbg     = !cpu_req;
`else
    last_dbg_d   = last_dbg_q;
    // On a tie the port that did not win last time goes first.
    pick_dbg     = dbg_req && (!cpu_req || !last_dbg_q);
`endif

    case (state_q)
      S_IDLE: begin
        if (cpu_req || dbg_req) begin
          state_d      = S_ACCESS;
          cnt_d        = LAT_M1;
          win_dbg_d    = pick_dbg;
          cpu_grant_d  = !pick_dbg;
          dbg_grant_d  = pick_dbg;
          mem_enable_d = 1'b1;
          mem_write_d  = pick_dbg ? dbg_write : cpu_write;
          mem_addr_d   = pick_dbg ? dbg_addr  : cpu_addr;
          mem_wdata_d  = pick_dbg ? dbg_wdata : cpu_wdata;
`ifndef DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN
          last_dbg_d   = pick_dbg;
`endif
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d      = S_DONE;
          mem_enable_d = 1'b0;
          cpu_done_d   = !win_dbg_q;
          dbg_done_d   = win_dbg_q;
          if (!mem_write_q) begin
            if (win_dbg_q) dbg_rdata_d = mem_rdata;
            else           cpu_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d      = S_IDLE;
        mem_enable_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      win_dbg_q    <= 1'b0;
      cpu_grant_q  <= 1'b0;
      dbg_grant_q  <= 1'b0;
      cpu_done_q   <= 1'b0;
      dbg_done_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
`ifndef DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN
      last_dbg_q   <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      win_dbg_q    <= win_dbg_d;
      cpu_grant_q  <= cpu_grant_d;
      dbg_grant_q  <= dbg_grant_d;
      cpu_done_q   <= cpu_done_d;
      dbg_done_q   <= dbg_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
`ifndef DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN
      last_dbg_q   <= last_dbg_d;
`endif
    end
  end

  assign cpu_grant  = cpu_grant_q;
  assign dbg_grant  = dbg_grant_q;
  assign cpu_done   = cpu_done_q;
  assign dbg_done   = dbg_done_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign mem_enable = mem_enable_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: two instances (MEM_LATENCY 1 and 3), directed steps plus random traffic.
// Expected values come from a transaction-level model of memory contents, rdata registers and arbitration order.
module tb_data_memory_arbiter;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  // Index [k][p]: k = instance (0: latency 1, 1: latency 3), p = port (0: cpu, 1: dbg).
  logic        req [2][2];
  logic        wr  [2][2];
  logic [9:0]  ad  [2][2];
  logic [31:0] wd  [2][2];
  wire         gnt [2][2];
  wire         dn  [2][2];
  wire  [31:0] rd  [2][2];
  wire         men [2];
  wire         mwr [2];
  wire  [9:0]  mad [2];
  wire  [31:0] mwd [2];
  logic [31:0] mrd [2];
  wire         bsy [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    data_memory_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_LATENCY((g == 0) ? 1 : 3)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .cpu_req(req[g][0]), .cpu_write(wr[g][0]), .cpu_addr(ad[g][0]), .cpu_wdata(wd[g][0]),
      .cpu_grant(gnt[g][0]), .cpu_done(dn[g][0]), .cpu_rdata(rd[g][0]),
      .dbg_req(req[g][1]), .dbg_write(wr[g][1]), .dbg_addr(ad[g][1]), .dbg_wdata(wd[g][1]),
      .dbg_grant(gnt[g][1]), .dbg_done(dn[g][1]), .dbg_rdata(rd[g][1]),
      .mem_enable(men[g]), .mem_write(mwr[g]), .mem_addr(mad[g]), .mem_wdata(mwd[g]),
      .mem_rdata(mrd[g]), .busy(bsy[g])
    );
  end

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Memory arrays: read data is only valid in the last cycle of the latency window.
  logic [31:0] mem_arr [2][1024];
  int          en_cnt  [2];
  logic        poke_vld = 1'b0;
  int          poke_k;
  logic [9:0]  poke_addr;
  logic [31:0] poke_dat;

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (men[k]) begin
        en_cnt[k] <= en_cnt[k] + 1;
        if (mwr[k]) mem_arr[k][mad[k]] <= mwd[k];
      end else begin
        en_cnt[k] <= 0;
      end
    end
    if (poke_vld) mem_arr[poke_k][poke_addr] <= poke_dat;
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mrd[k] = 32'hBAD0BAD0;
      if (men[k] && en_cnt[k] == lat(k) - 1) mrd[k] = mem_arr[k][mad[k]];
    end
  end

  // Reference model.
  logic [31:0] ref_mem [2][1024];
  bit          ref_ok  [2][1024];
  logic [31:0] ref_rd  [2][2];
  bit          ref_last_dbg [2];
  bit          pend [2][2];
  int          n_cmp = 0;
  int          n_err = 0;
  int          last_port;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ref_last_dbg[k] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        ref_rd[k][p] = '0;
        pend[k][p]   = 1'b0;
        req[k][p]    = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic poke(input int k, input logic [9:0] a, input logic [31:0] d);
    poke_k = k; poke_addr = a; poke_dat = d; poke_vld = 1'b1;
    cyc();
    poke_vld = 1'b0;
    ref_mem[k][a] = d;
    ref_ok[k][a]  = 1'b1;
  endtask

  task automatic raise(input int k, input int p, input logic w, input logic [9:0] a, input logic [31:0] d);
    req[k][p] = 1'b1; wr[k][p] = w; ad[k][p] = a; wd[k][p] = d;
    pend[k][p] = 1'b1;
  endtask

  function automatic int exp_winner(input int k);
`ifdef DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN
    return pend[k][0] ? 0 : 1;
`else
    if (pend[k][0] && pend[k][1]) return ref_last_dbg[k] ? 0 : 1;
    return pend[k][0] ? 0 : 1;
`endif
  endfunction

  // Runs one whole transfer from the IDLE cycle in which the request is visible.
  task automatic serve(input int k);
    int w, waited;
    logic [9:0] ea;
    logic ew;
    logic [31:0] ed;
    w = exp_winner(k); ea = ad[k][w]; ew = wr[k][w]; ed = wd[k][w];
    waited = 0;
    while (!(gnt[k][0] || gnt[k][1]) && waited < 20) begin
      cyc();
      waited++;
    end
    chk("grant_latency", waited, 1);
    if (waited >= 20) begin
      model_reset();
      return;
    end
    last_port = gnt[k][1] ? 1 : 0;
    chk("grant_cpu", gnt[k][0], w == 0);
    chk("grant_dbg", gnt[k][1], w == 1);
    chk("access_enable", men[k], 1'b1);
    chk("access_addr", mad[k], ea);
    chk("access_write", mwr[k], ew);
    chk("access_busy", bsy[k], 1'b1);
    if (ew) chk("access_wdata", mwd[k], ed);
    // Changes after the grant must not reach the memory.
    req[k][w] = 1'b0; pend[k][w] = 1'b0;
    ad[k][w] = ea + 10'd2; wd[k][w] = ~ed; wr[k][w] = ~ew;
    ref_last_dbg[k] = (w == 1);
    for (int i = 1; i < lat(k); i++) begin
      cyc();
      chk("access_grant_low", {gnt[k][0], gnt[k][1]}, 0);
      chk("access_enable_hold", men[k], 1'b1);
      chk("access_addr_hold", mad[k], ea);
      chk("access_write_hold", mwr[k], ew);
      chk("access_done_low", {dn[k][0], dn[k][1]}, 0);
    end
    cyc();
    chk("done_winner", dn[k][w], 1'b1);
    chk("done_other", dn[k][1-w], 1'b0);
    chk("done_enable_low", men[k], 1'b0);
    chk("done_busy", bsy[k], 1'b1);
    if (ew) begin
      ref_mem[k][ea] = ed;
      ref_ok[k][ea]  = 1'b1;
    end else begin
      ref_rd[k][w] = ref_mem[k][ea];
    end
    chk("cpu_rdata", rd[k][0], ref_rd[k][0]);
    chk("dbg_rdata", rd[k][1], ref_rd[k][1]);
    cyc();
    chk("idle_done_low", {dn[k][0], dn[k][1]}, 0);
    chk("idle_busy_low", bsy[k], 1'b0);
  endtask

  initial begin
    logic [3:0] order;
    logic [9:0] a;
    bit         w;
    int         mask;

    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        wr[k][p] = 1'b0; ad[k][p] = '0; wd[k][p] = '0;
      end
    reset_n = 1'b0;
    model_reset();
    cyc();
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("reset_ctrl", {gnt[k][0], gnt[k][1], dn[k][0], dn[k][1], men[k], mwr[k], bsy[k]}, 0);
      chk("reset_mem_addr", mad[k], 0);
      chk("reset_mem_wdata", mwd[k], 0);
      chk("reset_cpu_rdata", rd[k][0], 0);
      chk("reset_dbg_rdata", rd[k][1], 0);
    end
    poke(0, 10'd5, 32'hDEADBEEF);
    poke(1, 10'd5, 32'hDEADBEEF);
    reset_n = 1'b1;
    cyc();

    // cpu load from address 5, latency 1.
    raise(0, 0, 1'b0, 10'd5, 32'h0);
    serve(0);
    chk("t1_cpu_rdata", rd[0][0], 32'hDEADBEEF);

    // dbg store to the top address, then cpu load of it.
    raise(0, 1, 1'b1, 10'd1023, 32'h12345678);
    serve(0);
    raise(0, 0, 1'b0, 10'd1023, 32'h0);
    serve(0);
    chk("t2_cpu_rdata", rd[0][0], 32'h12345678);
    chk("t2_dbg_rdata", rd[0][1], 32'h0);

    // Both ports hold their requests for four transfers, starting from reset.
    do_reset();
    raise(0, 0, 1'b0, 10'd5, 32'h0);
    raise(0, 1, 1'b0, 10'd1023, 32'h0);
    order = '0;
    for (int i = 0; i < 4; i++) begin
      serve(0);
      order[i] = (last_port == 1);
      if (last_port == 0) raise(0, 0, 1'b0, 10'd5, 32'h0);
      else                raise(0, 1, 1'b0, 10'd1023, 32'h0);
    end
    model_reset();
`ifdef DATA_MEMORY_ARBITER_FIXED_PRIORITY_EN
    chk("t3_grant_order", order, 4'b0000);
`else
    chk("t3_grant_order", order, 4'b1010);
`endif
    cyc();

    // Latency 3 load and address change during ACCESS.
    raise(1, 0, 1'b0, 10'd5, 32'h0);
    serve(1);
    chk("t4_cpu_rdata", rd[1][0], 32'hDEADBEEF);
    raise(1, 1, 1'b1, 10'd7, 32'hCAFE0007);
    serve(1);
    raise(1, 0, 1'b0, 10'd7, 32'h0);
    serve(1);
    chk("t6_cpu_rdata", rd[1][0], 32'hCAFE0007);

    // Reset asserted in the second ACCESS cycle.
    raise(1, 0, 1'b0, 10'd5, 32'h0);
    cyc();
    chk("t5_grant", gnt[1][0], 1'b1);
    req[1][0] = 1'b0;
    cyc();
    chk("t5_enable_before", men[1], 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t5_async_ctrl", {gnt[1][0], gnt[1][1], dn[1][0], dn[1][1], men[1], bsy[1]}, 0);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t5_no_done", {dn[1][0], dn[1][1], bsy[1]}, 0);
    end
    reset_n = 1'b1;
    cyc();
    raise(1, 0, 1'b0, 10'd5, 32'h0);
    serve(1);
    chk("t5_after_rdata", rd[1][0], 32'hDEADBEEF);

    // Random traffic on both instances.
    for (int k = 0; k < 2; k++) begin
      for (int it = 0; it < 30; it++) begin
        if (!pend[k][0] && !pend[k][1]) begin
          mask = $urandom_range(1, 3);
          for (int p = 0; p < 2; p++) begin
            if (mask[p]) begin
              a = $urandom_range(0, 1) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(1016, 1023));
              w = $urandom_range(0, 1) == 1;
              if (!ref_ok[k][a]) w = 1'b1;
              raise(k, p, w, a, $urandom);
            end
          end
        end
        serve(k);
      end
      for (int i = 0; i < 2; i++)
        if (pend[k][0] || pend[k][1]) serve(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
